// File: rtl/spi_master_mcs_pkg.sv
// Shared types for spi_master_mcs: FSM states, latched per-command config, edge-counter sizing.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    CS_HELD,
    GAP
  } spi_state_e;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_DIV_W  = 8;

  function automatic int edge_cnt_w(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction

  // Counts 0 .. 2*DATA_W SCLK edges of one word
  localparam int EDGE_W = edge_cnt_w(SPI_DATA_W);

  typedef struct packed {
    logic [SPI_DIV_W-1:0] div;
    logic                 cpol;
    logic                 cpha;
  } spi_cfg_t;

endpackage

// File: rtl/spi_master_mcs_if.sv
// Command (valid/ready) and response (one-cycle pulse) bundle of spi_master_mcs.
interface spi_master_mcs_if #(
  parameter int DATA_W = 8,
  parameter int CS_W   = 2
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic [CS_W-1:0]   cmd_cs;
  logic              cmd_last;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_data, cmd_cs, cmd_last,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_cs, cmd_last,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/spi_master_mcs_tick_gen.sv
// Half-period timer: down-counter reloaded on FSM state entry, ticks once every div_i+1 cycles.
module spi_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reload_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload_i || cnt_q == '0) begin
      cnt_d = div_i;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master_mcs.sv
// Multi-chip-select SPI master, all CPOL/CPHA modes, CS held across back-to-back words.
// Optional SPI_LOOPBACK_EN adds cfg_loopback to feed MOSI back into the receive shifter.
module spi_master_mcs
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = SPI_DIV_W,
  parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
`ifdef SPI_LOOPBACK_EN
  input  logic              cfg_loopback,
`endif
  spi_master_mcs_if.slave   bus,
  output logic              busy,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int EDGE_CNT_W = edge_cnt_w(DATA_W);

  spi_state_e              state_q, state_d;
  spi_cfg_t                cfg_q, cfg_d;
  logic [DATA_W-1:0]       tx_q, tx_d;
  logic [DATA_W-1:0]       rx_q, rx_d;
  logic [CS_W-1:0]         cs_q, cs_d;
  logic                    last_q, last_d;
  logic [EDGE_CNT_W-1:0]   edge_q, edge_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic [NUM_CS-1:0]       cs_n_q, cs_n_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;

  logic                    cmd_ready;
  logic                    accept;
  logic                    tick;
  logic                    reload;
  logic [DIV_W-1:0]        reload_div;
  logic                    rx_in;
  logic                    lead;
  logic [NUM_CS-1:0]       cmd_sel;
  logic [NUM_CS-1:0]       cur_sel;

  assign cmd_ready = (state_q == IDLE) || (state_q == CS_HELD);
  assign accept    = bus.cmd_valid && cmd_ready;

  // Out-of-range indices match no bit, so no CS is asserted for them
  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
    assign cmd_sel[gi] = (bus.cmd_cs == CS_W'(gi));
    assign cur_sel[gi] = (cs_q == CS_W'(gi));
  end

`ifdef SPI_LOOPBACK_EN
  logic lb_q, lb_d;
  assign rx_in = lb_q ? mosi_q : spi_miso;

  always_comb begin
    lb_d = lb_q;
    if (accept) lb_d = cfg_loopback;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) lb_q <= 1'b0;
    else              lb_q <= lb_d;
  end
`else
  assign rx_in = spi_miso;
`endif

  // Every state entry restarts the half-period timer; on accept the new divider applies at once
  assign reload     = (state_d != state_q);
  assign reload_div = accept ? cfg_div : DIV_W'(cfg_q.div);

  spi_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk      (axi_aclk),
    .rst_n    (axi_aresetn),
    .reload_i (reload),
    .div_i    (reload_div),
    .tick_o   (tick)
  );

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cs_d        = cs_q;
    last_d      = last_q;
    edge_d      = edge_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    lead        = 1'b0;

    if (accept) begin
      cfg_d.div  = SPI_DIV_W'(cfg_div);
      cfg_d.cpol = cfg_cpol;
      cfg_d.cpha = cfg_cpha;
      tx_d       = bus.cmd_data;
      rx_d       = '0;
      cs_d       = bus.cmd_cs;
      last_d     = bus.cmd_last;
      edge_d     = '0;
      if (!cfg_cpha) mosi_d = bus.cmd_data[DATA_W-1];
    end

    unique case (state_q)
      IDLE: begin
        sclk_d = cfg_cpol;
        if (accept) begin
          state_d = SETUP;
          cs_n_d  = ~cmd_sel;
        end
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          lead   = ~edge_q[0];
          if (lead ^ cfg_q.cpha) begin
            rx_d = (rx_q << 1) | DATA_W'(rx_in);
          end else begin
            mosi_d = cfg_q.cpha ? tx_q[DATA_W-1] : tx_q[DATA_W-2];
            tx_d   = tx_q << 1;
          end
          if (edge_q == EDGE_CNT_W'(2 * DATA_W - 1)) begin
            state_d     = HOLD;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_d;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (last_q) begin
            state_d = IDLE;
            cs_n_d  = '1;
          end else begin
            state_d = CS_HELD;
          end
        end
      end
      CS_HELD: begin
        sclk_d = cfg_cpol;
        if (accept) begin
          if (bus.cmd_cs == cs_q) begin
            state_d = SHIFT;
          end else begin
            state_d = GAP;
            cs_n_d  = '1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          state_d = SETUP;
          cs_n_d  = ~cur_sel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      cs_q        <= '0;
      last_q      <= 1'b0;
      edge_q      <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= '1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cs_q        <= cs_d;
      last_q      <= last_d;
      edge_q      <= edge_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != IDLE);
  assign spi_sclk      = sclk_q;
  assign spi_mosi      = mosi_q;
  assign spi_cs_n      = cs_n_q;

endmodule

// File: doc/spi_master_mcs.md
Name: spi_master_mcs

Overview:
Parametrised SPI master for the MicroZed PL, clocked from the PS-supplied AXI clock. It is the successor to the fixed single-device SPI path, adding configurable word width, multiple chip selects, all four CPOL/CPHA modes, a runtime clock divider and CS-hold across back-to-back words. Commands enter on a valid/ready interface. Received words leave on a one-cycle pulse interface toward the register/DMA front end.

Parameters:
DATA_W, 8, bits per SPI word; shifted MSB first.
NUM_CS, 4, number of chip-select outputs.
DIV_W, 8, width of the clock-divider config.
CS_W, $clog2(NUM_CS) (minimum 1), derived width of the chip-select index.

Ports:
axi_aclk  in  1  system clock.
axi_aresetn  in  1  asynchronous active-low reset.
cfg_div  in  DIV_W  half-period length D = cfg_div+1 clocks.
cfg_cpol  in  1  SCLK idle level.
cfg_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accepted when valid && ready.
cmd_data  in  DATA_W  word to transmit.
cmd_cs  in  CS_W  target chip select.
cmd_last  in  1  release CS after this word.
rsp_valid  out  1  one-cycle pulse with the received word.
rsp_data  out  DATA_W  received word; held until the next pulse.
busy  out  1  high when not in IDLE.
spi_sclk  out  1  serial clock.
spi_mosi  out  1  serial data out.
spi_miso  in  1  serial data in.
spi_cs_n  out  NUM_CS  active-low chip selects.

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0, spi_sclk=0, spi_mosi=0, spi_cs_n=all 1s, state=IDLE. Reset is asynchronous; asserting it mid-transfer aborts immediately.
- cfg_div, cfg_cpol and cfg_cpha are latched at command acceptance. Changes while busy are ignored.
- In IDLE and CS_HELD, spi_sclk follows the registered cfg_cpol (one cycle late).
- IDLE:
  - cmd_ready=1. On accept: latch the command, go to SETUP; the selected spi_cs_n goes low the next cycle.
- SETUP:
  - Lasts D cycles. For CPHA=0, MOSI presents bit DATA_W-1. Then go to SHIFT.
- SHIFT:
  - 2*DATA_W half-periods of D cycles; SCLK toggles at the end of each half-period.
  - CPHA=0: sample MISO on the leading edge, update MOSI on the trailing edge.
  - CPHA=1: update MOSI on the leading edge, sample on the trailing edge.
  - After the final edge, go to HOLD.
- HOLD:
  - On entry, rsp_valid pulses for 1 cycle and rsp_data is loaded. No backpressure is applied on rsp.
  - HOLD lasts D cycles. If cmd_last=1, release CS and go to IDLE; otherwise go to CS_HELD.
- CS_HELD:
  - CS stays low and cmd_ready=1.
  - Accepting a command with the same cs goes directly to SHIFT; the first bit is set up on entry and the first edge comes D cycles later.
  - Accepting a command with a different cs releases CS and goes to GAP.
- GAP:
  - All CS high for D cycles, then SETUP with the new cs.
- cmd_ready=0 in SETUP, SHIFT, HOLD and GAP.
- Latency (DATA_W=8, cfg_div=1, so D=2; accept at cycle 0):
  - cs_n low at cycle 1.
  - First SCLK edge at cycle 5.
  - rsp_valid at cycle 35.
  - CS high and cmd_ready at cycle 37 when cmd_last=1.
- cmd_cs >= NUM_CS: the command is accepted and the transfer runs with no CS asserted; rsp is still produced.
- cfg_div=0 gives D=1, so SCLK = axi_aclk/2.
- MISO is sampled directly with no synchroniser; the output timing constraint limits the SCLK rate.

Optional Feature:
SPI_LOOPBACK_EN
- Defined: adds input port cfg_loopback (1 bit, latched at accept). When it is 1, the receive shifter takes spi_mosi instead of spi_miso. Pins behave unchanged.
- Undefined: the port is absent and the receive path is always spi_miso.

Decomposition:
- spi_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD, CS_HELD, GAP);
  - the latched config struct (div, cpol, cpha);
  - a localparam for the edge-count width, $clog2(2*DATA_W+1).
- Sub-module spi_tick_gen: DIV_W down-counter, reloaded on state entry, emitting a 1-cycle half-period tick.

Test Plan:
1. Mode 0, div=1, cmd 0xA5 cs=2 last=1, MISO model returns 0x3C:
   - spi_cs_n = 4'b1011 during the transfer;
   - 16 SCLK edges, MOSI bits 10100101;
   - rsp_valid at cycle 35 with rsp_data=0x3C;
   - CS high and cmd_ready at cycle 37.
2. Modes 1, 2 and 3 with cmd 0x81:
   - SCLK idles at cpol;
   - the slave model captures 0x81 on the correct edge in each mode;
   - rsp matches the model.
3. Two commands cs=1 (last=0 then last=1): cs_n[1] stays low throughout with no GAP; two rsp pulses.
4. cs=0 last=0, then cs=3: all cs_n high for exactly D cycles between the transfers.
5. Assert reset mid-SHIFT: cs_n returns to all 1s, sclk=0 and busy=0 immediately; no rsp_valid pulse.
6. With SPI_LOOPBACK_EN and cfg_loopback=1, cmd 0x5A with MISO tied 0: rsp_data=0x5A.
